// File: rtl/cc_branch_unit_if.sv
// cc_branch_unit_if
//   Bundles the control strobes and status outputs of cc_branch_unit.
//   master: control FSM side (drives strobes, observes NZP/BEN/stack status).
//   slave : cc_branch_unit side.
//   Signals:
//     LD_CC, Bus      load NZP from the bus value
//     LD_PSR, PSR_NZP load NZP verbatim (RTI path)
//     LD_BEN, IR_NZP  load branch enable from IR[11:9] mask
//     Push, Pop       save / restore NZP on the CC stack
//     NZP, BEN        registered condition codes and branch enable
//     Count, Full, Empty, Err  stack occupancy, decoded flags, sticky error
interface cc_branch_unit_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             LD_CC;
  logic [WIDTH-1:0] Bus;
  logic             LD_PSR;
  logic [2:0]       PSR_NZP;
  logic             LD_BEN;
  logic [2:0]       IR_NZP;
  logic             Push;
  logic             Pop;
  logic [2:0]       NZP;
  logic             BEN;
  logic [CW-1:0]    Count;
  logic             Full;
  logic             Empty;
  logic             Err;

  modport master (
    output LD_CC, Bus, LD_PSR, PSR_NZP, LD_BEN, IR_NZP, Push, Pop,
    input  NZP, BEN, Count, Full, Empty, Err
  );

  modport slave (
    input  LD_CC, Bus, LD_PSR, PSR_NZP, LD_BEN, IR_NZP, Push, Pop,
    output NZP, BEN, Count, Full, Empty, Err
  );
endinterface

// File: rtl/cc_branch_unit.sv
// cc_branch_unit
//   LC-3 condition-code register, branch-enable register and a DEPTH-entry
//   LIFO of saved condition codes used on interrupt entry / RTI.
//   Ports:
//     Clk    rising-edge clock
//     Reset  synchronous, active-high
//     cc     cc_branch_unit_if.slave (strobes in; NZP, BEN, Count,
//            Full, Empty, Err out)
//   NZP, BEN, Count and Err are registered; Full/Empty decode Count.
module cc_branch_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic            Clk,
  input logic            Reset,
  cc_branch_unit_if.slave cc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // N/Z/P from a bus value: exactly one bit is set.
  function automatic logic [2:0] cc_from_bus(input logic signed [WIDTH-1:0] v);
    logic n;
    logic z;
    n = v[WIDTH-1];
    z = (v == '0);
    return {n, z, !n && !z};
  endfunction

  logic [2:0]    nzp_p1;
  logic          ben_p1;
  logic [CW-1:0] count_p1;
  logic          err_p1;
  logic [2:0]    stack_p1 [DEPTH];

  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic          err_set;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [2:0]    nzp_nxt;
  logic [CW-1:0] count_nxt;

  assign full  = (count_p1 == CW'(DEPTH));
  assign empty = (count_p1 == '0);

  // Simultaneous Push and Pop cancel each other and count as an error.
  assign push_ok = cc.Push && !cc.Pop && !full;
  assign pop_ok  = cc.Pop && !cc.Push && !empty;
  assign err_set = (cc.Push && cc.Pop) || (cc.Push && full) || (cc.Pop && empty);

  // Index truncation is safe: wr_idx is used only when not full,
  // rd_idx only when not empty.
  assign wr_idx = IW'(count_p1);
  assign rd_idx = IW'(count_p1 - CW'(1));

  always_comb begin
    nzp_nxt   = nzp_p1;
    count_nxt = count_p1;
    if (pop_ok) begin
      nzp_nxt   = stack_p1[rd_idx];
      count_nxt = count_p1 - CW'(1);
    end else if (cc.LD_PSR) begin
      nzp_nxt = cc.PSR_NZP;
    end else if (cc.LD_CC) begin
      nzp_nxt = cc_from_bus(cc.Bus);
    end
    if (push_ok) begin
      count_nxt = count_p1 + CW'(1);
    end
  end

  // ---- register stage p1: control state ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      nzp_p1   <= 3'b010;
      ben_p1   <= 1'b0;
      count_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      nzp_p1   <= nzp_nxt;
      count_p1 <= count_nxt;
      if (cc.LD_BEN) begin
        // Uses the pre-update NZP, so a same-cycle load does not leak in.
        ben_p1 <= |(cc.IR_NZP & nzp_p1);
      end
      if (err_set) begin
        err_p1 <= 1'b1;
      end
    end
  end

  // ---- register stage p1: stack storage (no reset) ----
  always_ff @(posedge Clk) begin
    if (!Reset && push_ok) begin
      stack_p1[wr_idx] <= nzp_p1;
    end
  end

  assign cc.NZP   = nzp_p1;
  assign cc.BEN   = ben_p1;
  assign cc.Count = count_p1;
  assign cc.Full  = full;
  assign cc.Empty = empty;
  assign cc.Err   = err_p1;
endmodule

// File: doc/cc_branch_unit.md
# cc_branch_unit

Parametrised condition-code and branch-enable unit for the LC-3 datapath. It registers N/Z/P from a WIDTH-bit bus value and computes the branch-enable bit from the IR condition mask. It also keeps a DEPTH-entry save/restore stack of condition codes for interrupt entry and RTI. It sits beside the register file and is driven by the control FSM (LD_CC, LD_BEN, save/restore strobes).

## Interface
- WIDTH, 16: bus width; sign bit is Bus[WIDTH-1]; WIDTH >= 2.
- DEPTH, 4: number of CC save-stack entries; DEPTH >= 1.
- CW, $clog2(DEPTH+1): derived width of Count.

- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- LD_CC  in  1  load NZP from Bus.
- Bus  in  WIDTH  value written to a register this cycle.
- LD_PSR  in  1  load NZP directly from PSR_NZP (RTI path).
- PSR_NZP  in  3  {N,Z,P} value for LD_PSR.
- LD_BEN  in  1  load BEN.
- IR_NZP  in  3  IR[11:9] branch mask {n,z,p}.
- Push  in  1  save current NZP onto stack.
- Pop  in  1  restore NZP from top of stack.
- NZP  out  3  registered {N,Z,P}.
- BEN  out  1  registered branch enable.
- Count  out  CW  stack occupancy, 0..DEPTH.
- Full  out  1  Count == DEPTH (combinational from Count).
- Empty  out  1  Count == 0 (combinational from Count).
- Err  out  1  sticky protocol-error flag.

## Operation
- Reset values: NZP = 3'b010, BEN = 0, Count = 0, Err = 0. Stack contents are don't-care.
- CC from Bus: N = Bus[WIDTH-1]; Z = (Bus == 0); P = !N && !Z. Exactly one bit is ever set by this path.
- NZP next-value priority, highest first:
  - valid Pop: NZP <= stack top.
  - LD_PSR: NZP <= PSR_NZP, loaded verbatim and not checked.
  - LD_CC: NZP <= CC from Bus.
  - otherwise NZP holds.
- BEN: on LD_BEN, BEN <= |(IR_NZP & NZP), using the registered (pre-update) NZP. A same-cycle NZP load does not affect that BEN. Without LD_BEN, BEN holds.
- Stack is LIFO:
  - Push stores the pre-update NZP at index Count and increments Count.
  - Pop reads index Count-1 and decrements Count.
- Error cases, each of which sets Err (sticky until Reset):
  - Push while Full: ignored; Count and contents unchanged.
  - Pop while Empty: ignored; the NZP priority falls through to LD_PSR/LD_CC.
  - Push and Pop in the same cycle: both ignored; Count unchanged; the NZP priority falls through.
- Push combined with LD_CC/LD_PSR is legal: the old NZP is saved and the new NZP is loaded.

## Timing
- All outputs are registered, except Full and Empty, which decode Count combinationally.
- Latency:
  - NZP visible 1 cycle after the load strobe.
  - BEN visible 1 cycle after LD_BEN.
  - Push/Pop reflected in Count 1 cycle later.
- Back-to-back:
  - LD_CC in cycle t followed by LD_BEN in cycle t+1 uses the cycle-t bus value.
  - Push every cycle fills DEPTH entries in DEPTH cycles; the next Push sets Err.
- Pop directly after Push returns the value pushed. Alternating Push/Pop at Count=0 is legal.
- Reset mid-operation overrides all strobes that cycle. Count returns to 0 and the stack is treated as empty.

## Test plan
- Reset, then idle → NZP=010, BEN=0, Count=0, Empty=1, Err=0.
- WIDTH=16, LD_CC with Bus=16'h8000, then 16'h0000, then 16'h0001 → NZP=100, 010, 001 on successive cycles.
- NZP=001, LD_BEN with IR_NZP=001 → BEN=1. LD_BEN with IR_NZP=110 → BEN=0. Same-cycle LD_CC(Bus=0) + LD_BEN(IR_NZP=010) with NZP=001 → BEN=0, NZP=010.
- DEPTH=4: push NZP values 100, 010, 001, 100 (LD_PSR between pushes) → Full=1, Count=4. Fifth Push → Err=1, Count=4. Four Pops → NZP=100, 001, 010, 100, then Empty=1.
- Pop when Empty with LD_CC(Bus=16'hFFFF) → Err=1, NZP=100, Count=0. Push+Pop in the same cycle at Count=2 → Count=2, Err=1.
- Reset asserted mid-sequence with Count=3 and Push high → next cycle Count=0, NZP=010, BEN=0, Err=0.
